// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, word/state types, Rcon and S-box tables.
// The S-box table is also used by the cipher core.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [31:0] word_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_e;

   // Indexed directly by the round counter; entry 0 and 11-15 are unused padding.
   localparam logic [7:0] RCON [0:15] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES byte substitution via the shared table.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expansion.sv
// aes_key_expansion: iterative AES-128 key schedule, one round per clock,
// into an 11-slot round-key file read combinationally by Round_Sel.
// Optional feature macro AES_KEY_REUSE_EN: a Start carrying the key whose
// schedule is already resident skips expansion and just pulses Done.
module aes_key_expansion
   import aes_pkg::*;
(
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         Start,
   input  logic [127:0] Key,
   input  logic [3:0]   Round_Sel,
   output logic [127:0] Round_Key,
   output logic         Busy,
   output logic         Done,
   output logic         Key_Valid
);

   state_e       state_q, state_d;
   logic [3:0]   rc_q, rc_d;
   logic [127:0] slot_q [0:NUM_ROUNDS];
   logic [127:0] slot_d [0:NUM_ROUNDS];
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         key_valid_q, key_valid_d;

   logic [127:0] prev_key, next_key;
   word_t        w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
   logic         reuse_hit;

   // Select the previous round's slot (rc-1) as the expansion input.
   always_comb begin
      prev_key = '0;
      for (int i = 0; i < NUM_ROUNDS; i++)
         if (rc_q == 4'(i + 1)) prev_key = slot_q[i];
   end

   assign {w0, w1, w2, w3} = prev_key;
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sub
      aes_sbox u_sbox (.in_byte(rot[8*b +: 8]), .out_byte(sub[8*b +: 8]));
   end

   assign temp     = sub ^ {RCON[rc_q], 24'h0};
   assign n0       = w0 ^ temp;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEY_REUSE_EN
   logic [127:0] last_key_q, last_key_d;
   logic         last_vld_q, last_vld_d;

   assign reuse_hit = last_vld_q && key_valid_q && (Key == last_key_q);

   // Remember the key whose schedule has just been completed.
   always_comb begin
      last_key_d = last_key_q;
      last_vld_d = last_vld_q;
      if (state_q == IDLE && Start && !reuse_hit) begin
         last_vld_d = 1'b0;
      end else if (state_q == EXPAND && rc_q == 4'(NUM_ROUNDS)) begin
         last_key_d = slot_q[0];
         last_vld_d = 1'b1;
      end
   end

   // Stored-key registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_key_q <= '0;
         last_vld_q <= 1'b0;
      end else begin
         last_key_q <= last_key_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   assign reuse_hit = 1'b0;
`endif

   // Control FSM and slot writes: Start only in IDLE, one round per edge in EXPAND.
   always_comb begin
      state_d     = state_q;
      rc_d        = rc_q;
      slot_d      = slot_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      key_valid_d = key_valid_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (reuse_hit) begin
                  done_d = 1'b1;
               end else begin
                  slot_d[0]   = Key;
                  rc_d        = 4'd1;
                  busy_d      = 1'b1;
                  key_valid_d = 1'b0;
                  state_d     = EXPAND;
               end
            end
         end
         EXPAND: begin
            for (int i = 1; i <= NUM_ROUNDS; i++)
               if (rc_q == 4'(i)) slot_d[i] = next_key;
            if (rc_q == 4'(NUM_ROUNDS)) begin
               state_d     = IDLE;
               rc_d        = '0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               key_valid_d = 1'b1;
            end else begin
               rc_d = rc_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, status and key-file registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         rc_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_valid_q <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         rc_q        <= rc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         key_valid_q <= key_valid_d;
         for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= slot_d[i];
      end
   end

   // Zero-latency round-key read; out-of-range selects return zero.
   always_comb begin
      Round_Key = '0;
      for (int i = 0; i <= NUM_ROUNDS; i++)
         if (Round_Sel == 4'(i)) Round_Key = slot_q[i];
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Key_Valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// tb_aes_key_expansion: FIPS-197 vectors plus random keys against a
// textbook key-schedule model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expansion;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         Start = 1'b0;
   logic [127:0] Key = '0;
   logic [3:0]   Round_Sel = '0;
   logic [127:0] Round_Key;
   logic         Busy, Done, Key_Valid;

   aes_key_expansion dut (
      .CLK(CLK), .RST_N(RST_N), .Start(Start), .Key(Key), .Round_Sel(Round_Sel),
      .Round_Key(Round_Key), .Busy(Busy), .Done(Done), .Key_Valid(Key_Valid)
   );

   always #5 CLK = ~CLK;

   int           n_vec = 0;
   int           n_err = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];

   localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box = affine transform of the multiplicative inverse in GF(2^8).
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // FIPS-197 word-oriented KeyExpansion over 44 words.
   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic read_rk(input int sel, output logic [127:0] v);
      Round_Sel = 4'(sel);
      #1;
      v = Round_Key;
   endtask

   // Full expansion with optional stray Start sampled at edge E+inj_n.
   task automatic run_expand(input logic [127:0] k, input int inj_n,
                             input logic [127:0] inj_k, input string tag);
      int dones, lat;
      logic [127:0] v;
      dones = 0;
      lat   = -1;
      model_expand(k);
      Start = 1'b1;
      Key   = k;
      @(posedge CLK); #1;
      Start = 1'b0;
      chk($sformatf("%s_busy_e0", tag), Busy, 1);
      chk($sformatf("%s_kv_e0", tag), Key_Valid, 0);
      read_rk(0, v);
      chk($sformatf("%s_slot0", tag), v, exp_rk[0]);
      for (int n = 1; n <= 12; n++) begin
         if (n == inj_n) begin
            Start = 1'b1;
            Key   = inj_k;
         end
         @(posedge CLK); #1;
         Start = 1'b0;
         if (Done) begin
            dones++;
            if (lat < 0) lat = n;
         end
         if (n <= 10) begin
            read_rk(n, v);
            chk($sformatf("%s_slot%0d", tag, n), v, exp_rk[n]);
         end
         if (n < 10) chk($sformatf("%s_busy%0d", tag, n), Busy, 1);
         else begin
            chk($sformatf("%s_busy%0d", tag, n), Busy, 0);
            chk($sformatf("%s_kv%0d", tag, n), Key_Valid, 1);
         end
      end
      chk($sformatf("%s_latency", tag), 128'(lat), 128'(10));
      chk($sformatf("%s_done_count", tag), 128'(dones), 128'(1));
      for (int r = 0; r < 16; r++) begin
         read_rk(r, v);
         chk($sformatf("%s_final%0d", tag, r), v, (r <= 10) ? exp_rk[r] : 128'h0);
      end
   endtask

   initial begin
      logic [127:0] v, ka, kb;
      build_sbox();

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_kv", Key_Valid, 0);
      read_rk(0, v);  chk("rst_rk0", v, 0);
      read_rk(10, v); chk("rst_rk10", v, 0);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      // FIPS-197 A.1 and C.1
      run_expand(A1_KEY, 0, '0, "a1");
      read_rk(1, v);  chk("a1_fips_rk1", v, A1_RK1);
      read_rk(10, v); chk("a1_fips_rk10", v, A1_RK10);
      run_expand(C1_KEY, 0, '0, "c1");
      read_rk(10, v); chk("c1_fips_rk10", v, C1_RK10);
      read_rk(0, v);  chk("c1_fips_rk0", v, C1_KEY);

      // Start while busy, and on the Done edge, must be ignored
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      run_expand(ka, 4, kb, "busy_start");
      ka = {$urandom, $urandom, $urandom, $urandom};
      run_expand(ka, 10, kb, "done_edge_start");

      // Reset in the middle of an expansion
      Start = 1'b1;
      Key   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge CLK); #1;
      Start = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      chk("midrst_busy", Busy, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_kv", Key_Valid, 0);
      for (int s = 0; s < 16; s++) begin
         read_rk(s, v);
         chk($sformatf("midrst_rk%0d", s), v, 0);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      run_expand({$urandom, $urandom, $urandom, $urandom}, 0, '0, "post_rst");

      // Out-of-range select with a valid schedule
      read_rk(12, v);
      chk("sel12_zero", v, 0);

      // Random keys
      for (int t = 0; t < 6; t++)
         run_expand({$urandom, $urandom, $urandom, $urandom}, 0, '0, $sformatf("rnd%0d", t));

      // Repeating the resident key
      run_expand(A1_KEY, 0, '0, "a1_again");
`ifdef AES_KEY_REUSE_EN
      Start = 1'b1;
      Key   = A1_KEY;
      @(posedge CLK); #1;
      Start = 1'b0;
      chk("reuse_done", Done, 1);
      chk("reuse_busy", Busy, 0);
      chk("reuse_kv", Key_Valid, 1);
      @(posedge CLK); #1;
      chk("reuse_done_off", Done, 0);
      chk("reuse_busy2", Busy, 0);
      chk("reuse_kv2", Key_Valid, 1);
      read_rk(10, v);
      chk("reuse_rk10", v, A1_RK10);
      run_expand(C1_KEY, 0, '0, "reuse_newkey");
`else
      run_expand(A1_KEY, 0, '0, "a1_repeat");
      read_rk(10, v);
      chk("repeat_rk10", v, A1_RK10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
